msg_schedule: RTL and testbench
===============================

// Module: msg_schedule
// PURPOSE
//   Streaming SHA-2 message-schedule expander. Accepts one 16-word message block and
//   emits the round words W[0..ROUNDS-1] one per accepted handshake. Uses a 16-word
//   sliding window and the sigma0/sigma1 mixing functions.
//   Sits between the block padder and the compression-round datapath.
//   WORD_W=32 selects SHA-256 and WORD_W=64 selects SHA-512.
// PARAMETERS
//   WORD_W  32  word width: 32 = SHA-256 constants, 64 = SHA-512 constants; other values illegal
//   ROUNDS  64  number of words emitted per block (64 for SHA-256, 80 for SHA-512); must be >16
//   IDX_W   7   width of w_idx; must satisfy 2**IDX_W >= ROUNDS
// PORTS
//   clk        in   1          single clock; all state updates on the rising edge
//   rst_b      in   1          reset, synchronous, active-low
//   blk_valid  in   1          a message block is offered on blk_data
//   blk_ready  out  1          the block is accepted on this cycle if blk_valid=1
//   blk_data   in   16*WORD_W  message block; W[0] = MSB word, W[15] = LSB word
//   abort      in   1          synchronous flush of the current block
//   w_valid    out  1          w_data / w_idx hold a valid round word
//   w_ready    in   1          consumer accepts the word on this cycle
//   w_data     out  WORD_W     round word W[w_idx]
//   w_idx      out  IDX_W      round index t of w_data
//   busy       out  1          a block is being expanded (RUN state)
// BEHAVIOUR
//   Reset: at a clk edge with rst_b=0, state<=IDLE, window<=0, t<=0.
//     While rst_b=0, all outputs are forced to 0: blk_ready, w_valid, w_data, w_idx, busy.
//   Sigma functions (^ = XOR, ROTR = rotate right, SHR = logical shift right):
//     WORD_W=32: s0 = ROTR7^ROTR18^SHR3;  s1 = ROTR17^ROTR19^SHR10
//     WORD_W=64: s0 = ROTR1^ROTR8^SHR7;   s1 = ROTR19^ROTR61^SHR6
//   Window win[0..15] holds W[t..t+15]; win[0] is the word currently presented.
//   Next word W[t+16] = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2**WORD_W (carries dropped).
//   States:
//     IDLE: blk_ready = rst_b & ~abort; w_valid=0; busy=0.
//       On blk_valid & blk_ready: load win from blk_data, t<=0, go to RUN.
//     RUN: w_valid=1; busy=1; blk_ready=0; w_data=win[0]; w_idx=t.
//       On w_valid & w_ready: shift win down one place, win[15]<=W[t+16], t<=t+1.
//       On the handshake where t==ROUNDS-1: go to IDLE.
//   Latency: W[0] is valid on the cycle after block acceptance; full throughput is one word per cycle.
//   Backpressure: while w_ready=0 in RUN, w_data, w_idx and win hold stable.
//   Back-to-back blocks: IDLE lasts exactly one cycle between blocks, so the next block
//     is accepted no earlier than the cycle after the last word's handshake.
//   abort=1 at an edge in RUN: go to IDLE and drop the remaining words.
//     w_valid=0 from the next cycle.
//     The word presented on the abort cycle counts as not transferred, even if w_ready=1.
//   abort=1 in IDLE together with blk_valid=1: abort wins and the block is not accepted.
//   Reset asserted in RUN: same effect as abort, plus window and t are cleared.
//   w_idx never wraps; t stops at ROUNDS-1.
// STRUCTURE
//   Package sha_sched_pkg holds:
//     the state typedef {IDLE, RUN};
//     the rotate/shift constants of s0 and s1 for WORD_W=32 and WORD_W=64;
//     a compile-time legality check on WORD_W and ROUNDS.
//   Sub-module sched_sigma is purely combinational, with parameters WORD_W and SEL (0 = s0, 1 = s1).
//     It is instantiated twice.
//   The top level holds the FSM, counter t, window shift register and modular adder tree.
// TESTING
//   1. Reset: hold rst_b=0 for 3 cycles with blk_valid=1 -> all outputs 0 and no block accepted.
//      Release -> blk_ready=1.
//   2. WORD_W=32, "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1:
//      -> W0..W15 echo the block, W16=0x61626380, W17=0x000F0000.
//      -> 64 words total; w_idx runs 0..63; back to IDLE.
//   3. Backpressure: drop w_ready for 5 cycles at w_idx=20 -> w_data/w_idx held stable.
//      The word sequence is identical to case 2.
//   4. Back-to-back: second block offered during the last word of the first
//      -> accepted one cycle after the last handshake; its W0 appears on the next cycle.
//   5. Abort at w_idx=30 with w_ready=1 -> word 30 is not counted; w_valid=0 next cycle.
//      A new block is then accepted and restarts at w_idx=0.
//      Repeat case 5 with rst_b=0 instead of abort -> same result, window cleared.
//   6. WORD_W=64, ROUNDS=80, block W0=0x6162638000000000, W15=0x18:
//      -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 words emitted.

Source files
------------

// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA-2 message-schedule expander:
// FSM state encoding, sigma rotate/shift amounts, and a parameter legality test.
package sha_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Two rotate amounts and one logical shift make up each sigma function.
  typedef struct packed {
    logic [6:0] r1;
    logic [6:0] r2;
    logic [6:0] sh;
  } sigma_cfg_t;

  localparam sigma_cfg_t S0_256 = '{r1: 7'd7,  r2: 7'd18, sh: 7'd3};
  localparam sigma_cfg_t S1_256 = '{r1: 7'd17, r2: 7'd19, sh: 7'd10};
  localparam sigma_cfg_t S0_512 = '{r1: 7'd1,  r2: 7'd8,  sh: 7'd7};
  localparam sigma_cfg_t S1_512 = '{r1: 7'd19, r2: 7'd61, sh: 7'd6};

  function automatic sigma_cfg_t sigma_cfg(input int word_w, input bit sel);
    if (word_w == 64) return sel ? S1_512 : S0_512;
    return sel ? S1_256 : S0_256;
  endfunction

  function automatic bit params_legal(input int word_w, input int rounds, input int idx_w);
    return ((word_w == 32) || (word_w == 64)) && (rounds > 16) &&
           (idx_w >= 1) && (idx_w < 31) && ((1 << idx_w) >= rounds);
  endfunction

endpackage

// File: rtl/sched_sigma.sv
// Combinational SHA-2 small-sigma function: ROTR(r1) ^ ROTR(r2) ^ SHR(sh).
// SEL=0 selects s0, SEL=1 selects s1; WORD_W picks the SHA-256 or SHA-512 amounts.
module sched_sigma
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter bit SEL    = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam sigma_cfg_t CFG = sigma_cfg(WORD_W, SEL);
  localparam int R1 = int'(CFG.r1);
  localparam int R2 = int'(CFG.r2);
  localparam int SH = int'(CFG.sh);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  assign y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);

endmodule

// File: rtl/msg_schedule.sv
// Streaming SHA-2 message-schedule expander: takes one 16-word block and emits
// W[0..ROUNDS-1] one word per handshake from a 16-word sliding window.
module msg_schedule
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] blk_data,
  input  logic                 abort,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_data,
  output logic [IDX_W-1:0]     w_idx,
  output logic                 busy
);

  if (!params_legal(WORD_W, ROUNDS, IDX_W)) begin : g_illegal_params
    $error("msg_schedule: illegal WORD_W/ROUNDS/IDX_W combination");
  end

  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  t_q, t_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [WORD_W-1:0] s0_w, s1_w, w_new;

  sched_sigma #(.WORD_W(WORD_W), .SEL(1'b0)) u_s0 (.x(win_q[1]),  .y(s0_w));
  sched_sigma #(.WORD_W(WORD_W), .SEL(1'b1)) u_s1 (.x(win_q[14]), .y(s1_w));

  // W[t+16]; the sum is WORD_W wide so carries out of the top bit are dropped.
  assign w_new = s1_w + win_q[9] + s0_w + win_q[0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d   = state_q;
    t_d       = t_q;
    win_d     = win_q;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        blk_ready = ~abort;
        if (blk_valid && !abort) begin
          for (int i = 0; i < 16; i++) win_d[i] = blk_data[(15-i)*WORD_W +: WORD_W];
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        // An aborted word is never transferred, even if the consumer was ready.
        if (abort) begin
          state_d = IDLE;
        end else if (w_ready) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_new;
          if (t_q == LAST_T) state_d = IDLE;
          else               t_d     = t_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_b) begin
      blk_ready = 1'b0;
      w_valid   = 1'b0;
      busy      = 1'b0;
    end
  end

  assign w_data = rst_b ? win_q[0] : '0;
  assign w_idx  = rst_b ? t_q      : '0;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking here so every flop samples the pre-edge values of its peers.
    if (!rst_b) begin
      state_q <= IDLE;
      t_q     <= '0;
      // NOTE: the window is a flop array, not RAM, so clearing it on reset is cheap and well defined.
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: SHA-256 and SHA-512 instances, a
// schedule reference model feeding per-instance scoreboards, directed and random stimulus.
module tb_msg_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_b;
  logic         blk_valid32, blk_ready32, abort32, w_valid32, w_ready32, busy32;
  logic [511:0] blk_data32;
  logic [31:0]  w_data32;
  logic [6:0]   w_idx32;

  logic          blk_valid64, blk_ready64, abort64, w_valid64, w_ready64, busy64;
  logic [1023:0] blk_data64;
  logic [63:0]   w_data64;
  logic [6:0]    w_idx64;

  msg_schedule #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut32 (
    .clk(clk), .rst_b(rst_b), .blk_valid(blk_valid32), .blk_ready(blk_ready32),
    .blk_data(blk_data32), .abort(abort32), .w_valid(w_valid32), .w_ready(w_ready32),
    .w_data(w_data32), .w_idx(w_idx32), .busy(busy32)
  );

  msg_schedule #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
    .clk(clk), .rst_b(rst_b), .blk_valid(blk_valid64), .blk_ready(blk_ready64),
    .blk_data(blk_data64), .abort(abort64), .w_valid(w_valid64), .w_ready(w_ready64),
    .w_data(w_data64), .w_idx(w_idx64), .busy(busy64)
  );

  typedef struct {
    int              idx;
    longint unsigned data;
  } exp_t;

  exp_t            q32[$];
  exp_t            q64[$];
  longint unsigned model_w[80];
  longint unsigned got32[128];
  longint unsigned got64[128];
  int              last_idx32 = -1;
  int              last_idx64 = -1;
  bit              rnd32 = 1'b0;
  bit              rnd64 = 1'b0;
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: SHA-2 schedule recurrence with plain 64-bit arithmetic and masking.
  function automatic longint unsigned rotr(input longint unsigned x, input int n, input int ww);
    longint unsigned mask = (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    return ((x >> n) | (x << (ww - n))) & mask;
  endfunction

  function automatic longint unsigned sig(input longint unsigned x, input bit sel, input int ww);
    if (ww == 32)
      return sel ? (rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10))
                 : (rotr(x, 7, 32)  ^ rotr(x, 18, 32) ^ (x >> 3));
    return sel ? (rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6))
               : (rotr(x, 1, 64)  ^ rotr(x, 8, 64)  ^ (x >> 7));
  endfunction

  task automatic push_block(input bit is64, input logic [1023:0] blk);
    int              ww     = is64 ? 64 : 32;
    int              rounds = is64 ? 80 : 64;
    longint unsigned mask   = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    exp_t            e;
    for (int i = 0; i < 16; i++)
      model_w[i] = is64 ? 64'(blk[(15-i)*64 +: 64]) : 64'(blk[(15-i)*32 +: 32]);
    for (int t = 16; t < rounds; t++)
      model_w[t] = (sig(model_w[t-2], 1'b1, ww) + model_w[t-7] +
                    sig(model_w[t-15], 1'b0, ww) + model_w[t-16]) & mask;
    for (int t = 0; t < rounds; t++) begin
      e.idx  = t;
      e.data = model_w[t];
      if (is64) q64.push_back(e);
      else      q32.push_back(e);
    end
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitors: a word counts as transferred only on a clean handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b && w_valid32 && w_ready32 && !abort32) begin
      got32[w_idx32] = 64'(w_data32);
      last_idx32     = int'(w_idx32);
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon32_unexpected got idx=%0d data=0x%0h exp=no word", w_idx32, w_data32);
      end else begin
        e = q32.pop_front();
        check("mon32_idx", 64'(w_idx32), 64'(e.idx));
        check("mon32_data", 64'(w_data32), e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_b && w_valid64 && w_ready64 && !abort64) begin
      got64[w_idx64] = w_data64;
      last_idx64     = int'(w_idx64);
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon64_unexpected got idx=%0d data=0x%0h exp=no word", w_idx64, w_data64);
      end else begin
        e = q64.pop_front();
        check("mon64_idx", 64'(w_idx64), 64'(e.idx));
        check("mon64_data", w_data64, e.data);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd32) w_ready32 = ($urandom_range(0, 3) != 0);
    if (rnd64) w_ready64 = ($urandom_range(0, 3) != 0);
  end

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic send32(input logic [511:0] blk);
    bit ok = 1'b0;
    int n  = 0;
    blk_data32  = blk;
    blk_valid32 = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (blk_ready32) begin
        push_block(1'b0, {512'b0, blk});
        ok = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    blk_valid32 = 1'b0;
    if (!ok) check("send32_timeout", 0, 1);
  endtask

  task automatic send64(input logic [1023:0] blk);
    bit ok = 1'b0;
    int n  = 0;
    blk_data64  = blk;
    blk_valid64 = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (blk_ready64) begin
        push_block(1'b1, blk);
        ok = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    blk_valid64 = 1'b0;
    if (!ok) check("send64_timeout", 0, 1);
  endtask

  // Returns on the falling edge at which word idx is presented.
  task automatic wait_idx32(input int idx);
    bool_loop: for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (w_valid32 && int'(w_idx32) == idx) return;
    end
    check("wait_idx32_timeout", 0, 1);
  endtask

  task automatic wait_done32();
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (!busy32 && q32.size() == 0) done = 1'b1;
    end
    check("done32_queue_empty", 64'(q32.size()), 0);
    check("done32_last_idx", 64'(last_idx32), 63);
    @(posedge clk); #1;
  endtask

  task automatic wait_done64();
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (!busy64 && q64.size() == 0) done = 1'b1;
    end
    check("done64_queue_empty", 64'(q64.size()), 0);
    check("done64_last_idx", 64'(last_idx64), 79);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [511:0]  ABC32 = {32'h6162_6380, {14{32'h0}}, 32'h0000_0018};
  localparam logic [1023:0] ABC64 = {64'h6162_6380_0000_0000, {14{64'h0}}, 64'h18};

  initial begin
    logic [1023:0] r;
    rst_b       = 1'b0;
    blk_valid32 = 1'b1; blk_data32 = rand_blk()[511:0]; abort32 = 1'b0; w_ready32 = 1'b1;
    blk_valid64 = 1'b1; blk_data64 = rand_blk();        abort64 = 1'b0; w_ready64 = 1'b1;

    // Reset held with a block offered: outputs stay zero, nothing accepted.
    repeat (3) begin
      @(negedge clk);
      check("rst_outs32", {blk_ready32, w_valid32, busy32, w_data32, w_idx32}, 0);
      check("rst_outs64", 64'({blk_ready64, w_valid64, busy64, w_idx64}) | w_data64, 0);
    end
    @(posedge clk); #1;
    blk_valid32 = 1'b0; blk_valid64 = 1'b0; rst_b = 1'b1;
    @(negedge clk);
    check("post_rst_ready32", blk_ready32, 1);
    check("post_rst_busy32", busy32, 0);
    check("post_rst_ready64", blk_ready64, 1);

    // Abort beats a block offered in IDLE.
    @(posedge clk); #1;
    abort32 = 1'b1; blk_valid32 = 1'b1;
    @(negedge clk);
    check("idle_abort_ready", blk_ready32, 0);
    @(posedge clk); #1;
    abort32 = 1'b0; blk_valid32 = 1'b0;
    @(negedge clk);
    check("idle_abort_not_run", {busy32, w_valid32}, 0);
    @(posedge clk); #1;

    // "abc" block at full throughput.
    send32(ABC32);
    wait_done32();
    check("abc_w0", got32[0], 64'h6162_6380);
    check("abc_w15", got32[15], 64'h18);
    check("abc_w16", got32[16], 64'h6162_6380);
    check("abc_w17", got32[17], 64'h000F_0000);

    // Backpressure at word 20.
    send32(ABC32);
    wait_idx32(19);
    @(posedge clk); #1;
    w_ready32 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", w_valid32, 1);
      check("stall_idx", 64'(w_idx32), 20);
      check("stall_data", 64'(w_data32), model_w[20]);
    end
    @(posedge clk); #1;
    w_ready32 = 1'b1;
    wait_done32();

    // Back-to-back: next block offered during the last word.
    send32(ABC32);
    wait_idx32(62);
    @(posedge clk); #1;
    r = rand_blk();
    blk_data32  = r[511:0];
    blk_valid32 = 1'b1;
    @(negedge clk);
    check("b2b_last_idx", 64'(w_idx32), 63);
    check("b2b_not_ready_in_run", blk_ready32, 0);
    @(negedge clk);
    check("b2b_idle_ready", blk_ready32, 1);
    check("b2b_idle_no_valid", w_valid32, 0);
    push_block(1'b0, {512'b0, r[511:0]});
    @(posedge clk); #1;
    blk_valid32 = 1'b0;
    @(negedge clk);
    check("b2b_first_valid", w_valid32, 1);
    check("b2b_first_idx", 64'(w_idx32), 0);
    wait_done32();

    // Abort at word 30, then a fresh block restarts from index 0.
    r = rand_blk();
    send32(r[511:0]);
    wait_idx32(29);
    @(posedge clk); #1;
    abort32 = 1'b1;
    @(negedge clk);
    check("abort_presented_idx", 64'(w_idx32), 30);
    @(posedge clk); #1;
    abort32 = 1'b0;
    q32.delete();
    @(negedge clk);
    check("abort_valid_drop", w_valid32, 0);
    check("abort_busy_drop", busy32, 0);
    @(posedge clk); #1;
    r = rand_blk();
    send32(r[511:0]);
    wait_done32();

    // Reset at word 30: same as abort, and the window is cleared.
    r = rand_blk();
    send32(r[511:0]);
    wait_idx32(29);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    check("rst_run_outs", {blk_ready32, w_valid32, busy32, w_data32, w_idx32}, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    q32.delete();
    @(negedge clk);
    check("rst_run_valid", w_valid32, 0);
    check("rst_run_window", 64'(w_data32), 0);
    check("rst_run_idx", 64'(w_idx32), 0);
    check("rst_run_ready", blk_ready32, 1);
    @(posedge clk); #1;
    r = rand_blk();
    send32(r[511:0]);
    wait_done32();

    // Random blocks with random backpressure.
    rnd32 = 1'b1;
    repeat (3) begin
      r = rand_blk();
      send32(r[511:0]);
      wait_done32();
    end
    rnd32 = 1'b0;
    @(posedge clk); #1;
    w_ready32 = 1'b1;

    // SHA-512 instance.
    send64(ABC64);
    wait_done64();
    check("abc64_w16", got64[16], 64'h6162_6380_0000_0000);
    check("abc64_w17", got64[17], 64'h0003_0000_0000_00C0);
    rnd64 = 1'b1;
    repeat (2) begin
      send64(rand_blk());
      wait_done64();
    end
    rnd64 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
